// File: rtl/loadable_down_counter_pkg.sv
// rtl/loadable_down_counter_pkg.sv - shared state encoding and defaults for the loadable down counter
package loadable_down_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/loadable_down_counter_if.sv
// rtl/loadable_down_counter_if.sv - control/status bundle between a controller and the down counter
interface loadable_down_counter_if
  import loadable_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             tc;
  logic             busy;

  // Controller side: issues commands, observes counter status.
  modport master (
    output clr, load, load_val, en,
    input  count, zero, tc, busy
  );

  // Counter side.
  modport slave (
    input  clr, load, load_val, en,
    output count, zero, tc, busy
  );

endinterface

// File: rtl/loadable_down_counter.sv
// rtl/loadable_down_counter.sv - loadable down counter with underflow pulse; optional LOADABLE_DOWN_COUNTER_AUTO_RELOAD_EN
module loadable_down_counter
  import loadable_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  loadable_down_counter_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] wrap_val;

`ifdef LOADABLE_DOWN_COUNTER_AUTO_RELOAD_EN
  // Underflow restarts the countdown from the last loaded value.
  assign wrap_val = reload_q;
`else
  // Underflow rolls over to all-ones; reload is captured but not consumed.
  logic unused_reload;
  assign wrap_val      = '1;
  assign unused_reload = &{1'b0, reload_q};
`endif

  // Next-state and next-count: clr beats load beats en.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.clr) begin
      count_d = '0;
      state_d = IDLE;
    end else if (bus.load) begin
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      state_d  = RUN;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          if (bus.en) begin
            if (count_q == '0) begin
              count_d = wrap_val;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, count, reload and tc registers; reset is immediate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.zero  = (count_q == '0);
  assign bus.tc    = tc_q;
  assign bus.busy  = (state_q == RUN);

endmodule

// File: tb/tb_loadable_down_counter.sv
// tb/tb_loadable_down_counter.sv - self-checking bench for loadable_down_counter
module tb_loadable_down_counter;
  import loadable_down_counter_pkg::*;

  localparam int W    = DEFAULT_WIDTH;
  localparam int MAXV = (1 << W) - 1;
`ifdef LOADABLE_DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
  localparam int UF_T2 = 3;
`else
  localparam bit AUTO = 1'b0;
  localparam int UF_T2 = 15;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  loadable_down_counter_if #(.WIDTH(W)) bus ();

  loadable_down_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: count as plain integer, mode flag, last loaded value.
  int m_cnt, m_rel;
  bit m_run, m_tc;

  typedef struct {
    string nm;
    bit    clr;
    bit    load;
    int    val;
    bit    en;
    int    e_cnt;
    bit    e_tc;
    bit    e_busy;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic check_all(input string nm, input int e_cnt, input bit e_tc, input bit e_busy);
    chk({nm, ".count"}, int'(bus.count), e_cnt);
    chk({nm, ".tc"},    int'(bus.tc),    int'(e_tc));
    chk({nm, ".busy"},  int'(bus.busy),  int'(e_busy));
    chk({nm, ".zero"},  int'(bus.zero),  int'(e_cnt == 0));
  endtask

  task automatic drive(input bit c, input bit l, input int v, input bit e);
    logic [W-1:0] vv;
    vv = v[W-1:0];
    bus.clr = c; bus.load = l; bus.load_val = vv; bus.en = e;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_run = 0; m_tc = 0;
  endtask

  // Apply the counter's rules to whatever is currently driven.
  task automatic model_step();
    int v;
    v = int'(bus.load_val);
    m_tc = 0;
    if (bus.clr) begin
      m_cnt = 0; m_run = 0;
    end else if (bus.load) begin
      m_cnt = v; m_rel = v; m_run = 1;
    end else if (m_run && bus.en) begin
      if (m_cnt == 0) begin
        m_tc  = 1;
        m_cnt = AUTO ? m_rel : MAXV;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input string nm, input bit c, input bit l, input int v,
                              input bit e, input int ec, input bit et, input bit eb);
    vec_t x;
    x.nm = nm; x.clr = c; x.load = l; x.val = v; x.en = e;
    x.e_cnt = ec; x.e_tc = et; x.e_busy = eb;
    vecs.push_back(x);
  endfunction

  initial begin
    drive(0, 0, 0, 0);
    reset = 1'b0;
    model_reset();
    #2;
    check_all("reset", 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // 1: en ignored in IDLE
    for (int i = 0; i < 5; i++) add("idle_en", 0, 0, 0, 1, 0, 0, 0);
    // 2: load 3 and count through underflow
    add("t2_load", 0, 1, 3, 0, 3, 0, 1);
    add("t2_d2",   0, 0, 0, 1, 2, 0, 1);
    add("t2_d1",   0, 0, 0, 1, 1, 0, 1);
    add("t2_d0",   0, 0, 0, 1, 0, 0, 1);
    add("t2_uf",   0, 0, 0, 1, UF_T2, 1, 1);
    add("t2_hold", 0, 0, 0, 0, UF_T2, 0, 1);
    // 3: reload mid-run, en toggled
    add("t3_load", 0, 1, 6, 0, 6, 0, 1);
    add("t3_en1",  0, 0, 0, 1, 5, 0, 1);
    add("t3_en0",  0, 0, 0, 0, 5, 0, 1);
    add("t3_en1b", 0, 0, 0, 1, 4, 0, 1);
    // 4: load beats en at count 0
    add("t4_load0", 0, 1, 0, 0, 0, 0, 1);
    add("t4_ldwin", 0, 1, 9, 1, 9, 0, 1);
    // 5: clr beats load
    add("t5_clr",  1, 1, 7, 1, 0, 0, 0);
    add("t5_idle", 0, 0, 0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].load, vecs[i].val, vecs[i].en);
      model_step();
      tick();
      check_all(vecs[i].nm, vecs[i].e_cnt, vecs[i].e_tc, vecs[i].e_busy);
    end

    // Back-to-back underflows from zero
    drive(0, 1, 0, 0); model_step(); tick(); check_all("bb_load", 0, 0, 1);
    drive(0, 0, 0, 1); model_step(); tick(); check_all("bb_uf1", AUTO ? 0 : MAXV, 1, 1);
    model_step(); tick(); check_all("bb_uf2", AUTO ? 0 : MAXV - 1, AUTO, 1);

    // 6: async reset between edges
    drive(0, 1, 5, 0); model_step(); tick(); check_all("t6_load", 5, 0, 1);
    drive(0, 0, 0, 1); model_step(); tick(); check_all("t6_d4", 4, 0, 1);
    model_step(); tick(); check_all("t6_d3", 3, 0, 1);
    #2 reset = 1'b0;
    #1 check_all("t6_async", 0, 0, 0);
    model_reset();
    @(negedge clk); reset = 1'b1;

    // Async reset while tc is high
    drive(0, 1, 0, 0); model_step(); tick();
    drive(0, 0, 0, 1); model_step(); tick(); check_all("rst_tc_pre", AUTO ? 0 : MAXV, 1, 1);
    #2 reset = 1'b0;
    #1 check_all("rst_tc", 0, 0, 0);
    model_reset();
    @(negedge clk); reset = 1'b1;
    #1;

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        #1 check_all("rnd_rst", 0, 0, 0);
        model_reset();
        @(negedge clk); reset = 1'b1;
        #1;
      end
      drive($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
            int'($urandom_range(0, MAXV)), $urandom_range(0, 9) < 7);
      model_step();
      tick();
      check_all("rnd", m_cnt, m_tc, m_run);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
